servo_pwm_drv: RTL and testbench
================================

SERVO_PWM_DRV -- requirements
Module: servo_pwm_drv

Interface
REQ-001 The block SHALL have parameter PERIOD, default 1000000, frame length in clk cycles (20 ms at 50 MHz).
REQ-002 The block SHALL have parameter PW_MIN, default 18000, minimum high-pulse width in cycles.
REQ-003 The block SHALL have parameter PW_MAX, default 130000, maximum high-pulse width in cycles.
REQ-004 The block SHALL have parameter INIT_PW, default 74250, pulse width held in pw_active after reset.
REQ-005 The block SHALL have port clk, input, 1, single clock (50 MHz).
REQ-006 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port en, input, 1, level enable for frame generation.
REQ-008 The block SHALL have port pwm_cnt, input, 19, requested pulse width in cycles, from the servo position controller.
REQ-009 The block SHALL have port pwm_out, output, 1, registered servo pulse pin.
REQ-010 The block SHALL have port frame_start, output, 1, one-cycle strobe on the first high cycle of each frame.
REQ-011 The block SHALL have port pw_active, output, 19, width in use for the current frame.
REQ-012 The block SHALL have port clamped, output, 1, high for the whole frame when the sampled pwm_cnt was out of range.

Function
REQ-013 The block SHALL implement states IDLE, HIGH and LOW, with a 20-bit frame counter cnt.
REQ-014 IDLE SHALL hold pwm_out=0 and cnt=0; en=1 sampled in IDLE SHALL move the block to HIGH on the next edge.
REQ-015 On every entry into HIGH, the block SHALL: sample pwm_cnt, clamp it to [PW_MIN, PW_MAX], load it into pw_active, set clamped, pulse frame_start, set pwm_out=1 and set cnt=0 (same edge).
REQ-016 pwm_cnt SHALL be ignored at all other times; mid-frame changes SHALL take effect at the next frame.
REQ-017 HIGH SHALL move to LOW with pwm_out=0 on the edge where cnt==pw_active-1, so the pulse is exactly pw_active cycles.
REQ-018 LOW SHALL count to cnt==PERIOD-1; on that edge it SHALL re-enter HIGH (REQ-015) if en=1, otherwise go to IDLE. Frame length SHALL be exactly PERIOD cycles.
REQ-019 en deasserted during HIGH or LOW SHALL NOT truncate the frame; the current frame SHALL always complete.
REQ-020 Latency: en rising in IDLE at edge n SHALL give pwm_out=1 and frame_start=1 after edge n+1.
REQ-021 Clamp comparisons SHALL be unsigned 19-bit; pwm_cnt==PW_MIN or PW_MAX exactly SHALL give clamped=0.
REQ-022 cnt SHALL never exceed PERIOD-1 and SHALL NOT wrap.
REQ-023 Parameters SHALL satisfy 0<PW_MIN<=PW_MAX<PERIOD<2^20; violations SHALL be flagged at elaboration.

Reset
REQ-024 rst=1 at any edge, including mid-pulse, SHALL force state IDLE, pwm_out=0, frame_start=0, clamped=0, cnt=0 and pw_active=INIT_PW on that edge.
REQ-025 After rst falls with en=1, the first frame SHALL start per REQ-020.

Structure
REQ-026 The state encoding and the default PERIOD/PW_MIN/PW_MAX/INIT_PW constants SHALL live in the shared servo package, shared with the position controller.
REQ-027 The block SHALL be a single module with no sub-modules; the clamp SHALL be inline combinational logic feeding the pw_active register.

Verification (sim override: PERIOD=1000, PW_MIN=100, PW_MAX=800, INIT_PW=450)
REQ-028 Scenario: en=1 held, pwm_cnt=300 -> pwm_out high exactly 300 cycles per 1000-cycle frame; frame_start every 1000 cycles; clamped=0.
REQ-029 Scenario: pwm_cnt=50, then 900, then 100 on successive frames -> pw_active=100/clamped=1, then 800/clamped=1, then 100/clamped=0.
REQ-030 Scenario: pwm_cnt changes 300->600 at cycle 150 of a frame -> that frame stays 300 high; the next frame is 600 high.
REQ-031 Scenario: en dropped at cycle 200 of a frame -> the frame completes to 1000 cycles; the block then goes IDLE with pwm_out=0 and no further frame_start.
REQ-032 Scenario: rst pulsed at cycle 120 of a 300-wide pulse -> pwm_out=0 and pw_active=450 after that edge; with en=1 the next frame starts 1 cycle after rst falls.

Source files
------------

// File: rtl/servo_pwm_drv_pkg.sv
// Shared servo constants: default frame/pulse timing and the driver state encoding,
// also used by the position controller.
package servo_pwm_drv_pkg;

  localparam int unsigned DEF_PERIOD  = 32'd1000000;
  localparam int unsigned DEF_PW_MIN  = 32'd18000;
  localparam int unsigned DEF_PW_MAX  = 32'd130000;
  localparam int unsigned DEF_INIT_PW = 32'd74250;

  localparam int CNT_W = 20;
  localparam int PW_W  = 19;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

endpackage

// File: rtl/servo_pwm_drv.sv
// Servo PWM frame generator: one PERIOD-long frame per start, high for the clamped
// pulse width sampled at frame start; frames always run to completion.
module servo_pwm_drv
  import servo_pwm_drv_pkg::*;
#(
  parameter int unsigned PERIOD  = DEF_PERIOD,
  parameter int unsigned PW_MIN  = DEF_PW_MIN,
  parameter int unsigned PW_MAX  = DEF_PW_MAX,
  parameter int unsigned INIT_PW = DEF_INIT_PW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [PW_W-1:0] pwm_cnt,
  output logic            pwm_out,
  output logic            frame_start,
  output logic [PW_W-1:0] pw_active,
  output logic            clamped
);

  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(PERIOD - 32'd1);
  localparam logic [PW_W-1:0]  PW_MIN_C  = PW_W'(PW_MIN);
  localparam logic [PW_W-1:0]  PW_MAX_C  = PW_W'(PW_MAX);
  localparam logic [PW_W-1:0]  INIT_PW_C = PW_W'(INIT_PW);

  generate
    if (!((PW_MIN > 32'd0) && (PW_MIN <= PW_MAX) && (PW_MAX < PERIOD) &&
          (PERIOD < 32'd1048576))) begin : g_bad_params
      $error("servo_pwm_drv: need 0 < PW_MIN <= PW_MAX < PERIOD < 2^20");
    end
  endgenerate

  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             pwm_out_r;
  logic             frame_start_r;
  logic [PW_W-1:0]  pw_active_r;
  logic             clamped_r;

  logic [PW_W-1:0]  pw_next_s;
  logic             clamp_s;
  logic             start_frame_s;
  logic             pulse_end_s;
  logic             frame_end_s;

  // Clamp the requested width into [PW_MIN, PW_MAX]; bounds themselves pass unflagged.
  always_comb begin
    pw_next_s = pwm_cnt;
    clamp_s   = 1'b0;
    if (pwm_cnt < PW_MIN_C) begin
      pw_next_s = PW_MIN_C;
      clamp_s   = 1'b1;
    end else if (pwm_cnt > PW_MAX_C) begin
      pw_next_s = PW_MAX_C;
      clamp_s   = 1'b1;
    end else begin
      pw_next_s = pwm_cnt;
      clamp_s   = 1'b0;
    end
  end

  assign pulse_end_s = (cnt_r == {1'b0, pw_active_r - 19'd1});
  assign frame_end_s = (cnt_r == LAST_CNT);

  // A new frame starts from IDLE, or back-to-back at the last LOW cycle, only while enabled.
  always_comb begin
    start_frame_s = 1'b0;
    case (state_r)
      ST_IDLE: start_frame_s = en;
      ST_LOW:  start_frame_s = en & frame_end_s;
      default: start_frame_s = 1'b0;
    endcase
  end

  // Frame state machine and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      cnt_r         <= 20'd0;
      pwm_out_r     <= 1'b0;
      frame_start_r <= 1'b0;
      pw_active_r   <= INIT_PW_C;
      clamped_r     <= 1'b0;
    end else if (start_frame_s) begin
      state_r       <= ST_HIGH;
      cnt_r         <= 20'd0;
      pwm_out_r     <= 1'b1;
      frame_start_r <= 1'b1;
      pw_active_r   <= pw_next_s;
      clamped_r     <= clamp_s;
    end else begin
      frame_start_r <= 1'b0;
      case (state_r)
        ST_HIGH: begin
          cnt_r <= cnt_r + 20'd1;
          if (pulse_end_s) begin
            state_r   <= ST_LOW;
            pwm_out_r <= 1'b0;
          end else begin
            state_r   <= ST_HIGH;
            pwm_out_r <= 1'b1;
          end
        end
        ST_LOW: begin
          pwm_out_r <= 1'b0;
          if (frame_end_s) begin
            state_r <= ST_IDLE;
            cnt_r   <= 20'd0;
          end else begin
            state_r <= ST_LOW;
            cnt_r   <= cnt_r + 20'd1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          cnt_r     <= 20'd0;
          pwm_out_r <= 1'b0;
        end
      endcase
    end
  end

  assign pwm_out     = pwm_out_r;
  assign frame_start = frame_start_r;
  assign pw_active   = pw_active_r;
  assign clamped     = clamped_r;

endmodule

// File: tb/tb_servo_pwm_drv.sv
// Bench for servo_pwm_drv: directed scenarios plus random traffic, every cycle
// compared against a frame-level reference model.
module tb_servo_pwm_drv;

  localparam int PERIOD  = 1000;
  localparam int PW_MIN  = 100;
  localparam int PW_MAX  = 800;
  localparam int INIT_PW = 450;

  logic        clk;
  logic        rst;
  logic        en;
  logic [18:0] pwm_cnt;
  logic        pwm_out;
  logic        frame_start;
  logic [18:0] pw_active;
  logic        clamped;

  int checks = 0;
  int errors = 0;

  // reference model: frame running flag, position in frame, latched width/flag
  bit m_run = 1'b0;
  int m_pos = 0;
  int m_pw  = INIT_PW;
  bit m_cl  = 1'b0;

  servo_pwm_drv #(
    .PERIOD (PERIOD),
    .PW_MIN (PW_MIN),
    .PW_MAX (PW_MAX),
    .INIT_PW(INIT_PW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .pwm_cnt    (pwm_cnt),
    .pwm_out    (pwm_out),
    .frame_start(frame_start),
    .pw_active  (pw_active),
    .clamped    (clamped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_edge(input bit r, input bit e, input int req);
    bit start;
    if (r) begin
      m_run = 1'b0;
      m_pos = 0;
      m_pw  = INIT_PW;
      m_cl  = 1'b0;
    end else begin
      start = e && (!m_run || (m_pos == PERIOD - 1));
      if (start) begin
        m_run = 1'b1;
        m_pos = 0;
        m_cl  = (req < PW_MIN) || (req > PW_MAX);
        m_pw  = (req < PW_MIN) ? PW_MIN : ((req > PW_MAX) ? PW_MAX : req);
      end else if (m_run) begin
        if (m_pos == PERIOD - 1) begin
          m_run = 1'b0;
          m_pos = 0;
        end else begin
          m_pos++;
        end
      end
    end
  endfunction

  // one clock: advance the model with the inputs the DUT samples, then compare all outputs
  task automatic step();
    @(posedge clk);
    model_edge(rst, en, int'(pwm_cnt));
    #1;
    chk("pwm_out",     int'(pwm_out),     int'(m_run && (m_pos < m_pw)));
    chk("frame_start", int'(frame_start), int'(m_run && (m_pos == 0)));
    chk("pw_active",   int'(pw_active),   m_pw);
    chk("clamped",     int'(clamped),     int'(m_cl));
  endtask

  task automatic run_cycles(input int n, output int hi, output int fsn);
    hi  = 0;
    fsn = 0;
    for (int i = 0; i < n; i++) begin
      step();
      hi  += int'(pwm_out);
      fsn += int'(frame_start);
    end
  endtask

  initial begin
    int hi;
    int fsn;
    int hi2;
    int fs2;
    rst     = 1'b1;
    en      = 1'b0;
    pwm_cnt = 19'd0;

    // reset state
    run_cycles(3, hi, fsn);
    chk("reset_pw_active", int'(pw_active), INIT_PW);
    chk("reset_pwm_out", int'(pwm_out), 0);
    #3;

    // steady 300-wide frames
    rst     = 1'b0;
    en      = 1'b1;
    pwm_cnt = 19'd300;
    step();
    chk("first_frame_latency", int'(pwm_out & frame_start), 1);
    run_cycles(999, hi, fsn);
    chk("frame1_high", hi + 1, 300);
    chk("frame1_fs", fsn, 0);
    run_cycles(1000, hi, fsn);
    chk("frame2_high", hi, 300);
    chk("frame2_fs", fsn, 1);
    chk("frame2_clamped", int'(clamped), 0);

    // clamp boundaries on successive frames
    pwm_cnt = 19'd50;
    run_cycles(1000, hi, fsn);
    chk("lo_clamp_pw", int'(pw_active), 100);
    chk("lo_clamp_flag", int'(clamped), 1);
    chk("lo_clamp_high", hi, 100);
    pwm_cnt = 19'd900;
    run_cycles(1000, hi, fsn);
    chk("hi_clamp_pw", int'(pw_active), 800);
    chk("hi_clamp_flag", int'(clamped), 1);
    chk("hi_clamp_high", hi, 800);
    pwm_cnt = 19'd100;
    run_cycles(1000, hi, fsn);
    chk("min_exact_pw", int'(pw_active), 100);
    chk("min_exact_flag", int'(clamped), 0);
    pwm_cnt = 19'd800;
    run_cycles(1000, hi, fsn);
    chk("max_exact_flag", int'(clamped), 0);
    chk("max_exact_high", hi, 800);
    pwm_cnt = 19'h7FFFF;
    run_cycles(1000, hi, fsn);
    chk("max_code_pw", int'(pw_active), 800);

    // mid-frame request change takes effect next frame
    pwm_cnt = 19'd300;
    run_cycles(150, hi, fsn);
    pwm_cnt = 19'd600;
    run_cycles(850, hi2, fs2);
    chk("midchange_old_high", hi + hi2, 300);
    run_cycles(1000, hi, fsn);
    chk("midchange_new_high", hi, 600);

    // en dropped mid-frame: frame completes, then idle
    run_cycles(200, hi, fsn);
    en = 1'b0;
    run_cycles(800, hi2, fs2);
    chk("en_drop_high", hi + hi2, 600);
    run_cycles(50, hi, fsn);
    chk("idle_high", hi, 0);
    chk("idle_fs", fsn, 0);

    // reset in the middle of a pulse
    en      = 1'b1;
    pwm_cnt = 19'd300;
    run_cycles(120, hi, fsn);
    chk("pre_rst_high", int'(pwm_out), 1);
    rst = 1'b1;
    step();
    chk("rst_mid_pwm", int'(pwm_out), 0);
    chk("rst_mid_pw_active", int'(pw_active), INIT_PW);
    rst = 1'b0;
    step();
    chk("post_rst_start", int'(pwm_out & frame_start), 1);
    chk("post_rst_pw", int'(pw_active), 300);

    // random traffic against the model
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 3) == 0) pwm_cnt = 19'($urandom);
      else                           pwm_cnt = 19'($urandom_range(0, 1000));
      en  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 11) == 0);
      run_cycles(1, hi, fsn);
      rst = 1'b0;
      run_cycles(int'($urandom_range(1, 1400)), hi, fsn);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
